// File: rtl/vdp_port_arbiter_pkg.sv
// Shared types and helpers for the VDP CPU-port arbiter.
package vdp_port_pkg;

    localparam logic [1:0] PORT_DATA = 2'd0;
    localparam logic [1:0] PORT_CTRL = 2'd1;
    localparam logic [1:0] PORT_PAL  = 2'd2;
    localparam logic [1:0] PORT_IND  = 2'd3;

    typedef enum logic { OWN_CPU = 1'b0, OWN_INT = 1'b1 } owner_t;

    typedef enum logic [1:0] { IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2 } arb_state_t;

    typedef struct packed {
        logic       wrt;
        logic [1:0] adr;
        logic [7:0] dbo;
    } vdp_req_t;

    localparam int REQ_W = $bits(vdp_req_t);

    // Pair-phase tracking: bit 0 = ctrl port, bit 1 = palette port.
    // A write toggles that port's phase; a ctrl read resets the VDP
    // flip-flop, so it clears the ctrl phase.
    function automatic logic [1:0] phase_upd(input logic [1:0] ph, input vdp_req_t r);
        logic [1:0] n;
        n = ph;
        if (r.wrt) begin
            if (r.adr == PORT_CTRL)     n[0] = ~ph[0];
            else if (r.adr == PORT_PAL) n[1] = ~ph[1];
        end else if (r.adr == PORT_CTRL) begin
            n[0] = 1'b0;
        end
        return n;
    endfunction

endpackage

// File: rtl/vdp_port_arbiter_fifo.sv
// Bridge request queue: synchronous FIFO with full/empty flags.
// A push into a full queue is accepted when a pop happens the same cycle.
module vdp_req_fifo
    import vdp_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [REQ_W-1:0] din,
    input  logic             pop,
    output logic [REQ_W-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [REQ_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer bookkeeping; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: empty pointers make stale contents invisible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vdp_port_arbiter.sv
// Shares the VDP CPU port between the Z80 bus bridge (queued one-cycle pulses)
// and one internal requester, keeping ctrl/palette byte pairs atomic per owner.
module vdp_port_arbiter
    import vdp_port_pkg::*;
#(
    parameter int CPU_FIFO_DEPTH = 4,
    parameter int LOCK_TIMEOUT   = 64,
    parameter int MIN_GAP        = 2,
    parameter int READ_LAT       = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_req,
    input  logic       cpu_wrt,
    input  logic [1:0] cpu_adr,
    input  logic [7:0] cpu_dbo,
    output logic       cpu_ovf,
    input  logic       int_valid,
    output logic       int_ready,
    input  logic       int_wrt,
    input  logic [1:0] int_adr,
    input  logic [7:0] int_dbo,
    output logic       int_rvalid,
    output logic [7:0] int_rdata,
    output logic       lock_tmo,
    output logic       vdp_req,
    output logic       vdp_wrt,
    output logic [1:0] vdp_adr,
    output logic [7:0] vdp_dbo,
    input  logic [7:0] vdp_dbi
);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1) + 1;
    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(LOCK_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(MIN_GAP - 1);

    arb_state_t        state, state_nxt;
    owner_t            sel, sel_nxt;
    vdp_req_t          cpu_in, int_in, fifo_head, issue_req;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic              cpu_avail, issuing, cpu_issue, int_issue;
    logic [1:0]        cpu_phase, int_phase;
    logic              cpu_lock, int_lock, int_lock_eff, tmo_hit;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [READ_LAT:1] rd_pipe;
    logic [7:0]        rdata_q;

    assign cpu_in    = '{wrt: cpu_wrt, adr: cpu_adr, dbo: cpu_dbo};
    assign int_in    = '{wrt: int_wrt, adr: int_adr, dbo: int_dbo};
    assign issuing   = (state == ISSUE);
    assign cpu_issue = issuing && (sel == OWN_CPU);
    assign int_issue = issuing && (sel == OWN_INT);
    assign issue_req = (sel == OWN_CPU) ? fifo_head : int_in;
    assign fifo_pop  = cpu_issue;

    // A pulse arriving this cycle counts: it lands in the queue before ISSUE.
    assign cpu_avail = !fifo_empty || cpu_req;

    assign cpu_lock     = |cpu_phase;
    assign int_lock     = |int_phase;
    // An internal issue in the expiry cycle wins over the timeout.
    assign tmo_hit      = int_lock && (tmo_cnt >= TMO_LIMIT) && !int_issue;
    assign int_lock_eff = int_lock && !tmo_hit;

    assign vdp_req    = issuing;
    assign vdp_wrt    = issuing && issue_req.wrt;
    assign vdp_adr    = issuing ? issue_req.adr : 2'd0;
    assign vdp_dbo    = issuing ? issue_req.dbo : 8'd0;
    assign int_ready  = int_issue;
    assign lock_tmo   = tmo_hit;
    assign int_rvalid = rd_pipe[READ_LAT];
    assign int_rdata  = int_rvalid ? vdp_dbi : rdata_q;

    vdp_req_fifo #(.DEPTH(CPU_FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cpu_req),
        .din     (cpu_in),
        .pop     (fifo_pop),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State and winner registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sel   <= OWN_CPU;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    // Arbitration: the lock owner is exclusive; otherwise the bridge beats internal.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        case (state)
            IDLE: begin
                if (int_lock_eff) begin
                    if (int_valid) begin
                        state_nxt = ISSUE;
                        sel_nxt   = OWN_INT;
                    end
                end else if (cpu_avail) begin
                    state_nxt = ISSUE;
                    sel_nxt   = OWN_CPU;
                end else if (int_valid && !cpu_lock) begin
                    state_nxt = ISSUE;
                    sel_nxt   = OWN_INT;
                end
            end
            ISSUE:   state_nxt = (MIN_GAP > 1) ? GAP : IDLE;
            GAP:     if (gap_cnt <= GAP_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gap counter: GAP lasts MIN_GAP-1 cycles after each issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         gap_cnt <= '0;
        else if (issuing)                     gap_cnt <= GAP_LOAD;
        else if (state == GAP && gap_cnt != 0) gap_cnt <= gap_cnt - GAP_W'(1);
    end

    // Pair-phase bits per owner; an internal timeout drops its phases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_phase <= '0;
            int_phase <= '0;
        end else begin
            if (cpu_issue) cpu_phase <= phase_upd(cpu_phase, issue_req);
            if (int_issue)    int_phase <= phase_upd(int_phase, issue_req);
            else if (tmo_hit) int_phase <= '0;
        end
    end

    // Internal lock age: 1 in the cycle after the first byte, saturating at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   tmo_cnt <= '0;
        else if (int_issue && !int_lock) tmo_cnt <= TMO_W'(1);
        else if (!int_lock || tmo_hit)  tmo_cnt <= '0;
        else if (tmo_cnt < TMO_LIMIT)   tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    // Sticky overflow: a pulse into a full queue with no pop this cycle is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            cpu_ovf <= 1'b0;
        else if (cpu_req && fifo_full && !fifo_pop) cpu_ovf <= 1'b1;
    end

    // Internal read tracking: tap vdp_dbi READ_LAT cycles after the issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pipe <= '0;
            rdata_q <= '0;
        end else begin
            rd_pipe[1] <= int_issue && !issue_req.wrt;
            for (int k = 2; k <= READ_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
            if (int_rvalid) rdata_q <= vdp_dbi;
        end
    end

endmodule

// File: tb/tb_vdp_port_arbiter.sv
// Directed bench for vdp_port_arbiter: issue timing, pair locks, timeout,
// queue overflow, internal read capture and reset mid-operation.
module tb_vdp_port_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cpu_req, cpu_wrt, int_valid, int_wrt;
    logic [1:0] cpu_adr, int_adr;
    logic [7:0] cpu_dbo, int_dbo, vdp_dbi;
    logic       cpu_ovf, int_ready, int_rvalid, lock_tmo, vdp_req, vdp_wrt;
    logic [7:0] int_rdata, vdp_dbo;
    logic [1:0] vdp_adr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    vdp_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_wrt(cpu_wrt), .cpu_adr(cpu_adr), .cpu_dbo(cpu_dbo), .cpu_ovf(cpu_ovf),
        .int_valid(int_valid), .int_ready(int_ready), .int_wrt(int_wrt), .int_adr(int_adr), .int_dbo(int_dbo),
        .int_rvalid(int_rvalid), .int_rdata(int_rdata), .lock_tmo(lock_tmo),
        .vdp_req(vdp_req), .vdp_wrt(vdp_wrt), .vdp_adr(vdp_adr), .vdp_dbo(vdp_dbo), .vdp_dbi(vdp_dbi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an internal request, wait for acceptance, check the issued beat,
    // then drop valid one cycle later. Returns the issue cycle (-1 on timeout).
    task automatic int_issue(input logic w, input logic [1:0] a, input logic [7:0] d, output int t);
        int_valid = 1'b1; int_wrt = w; int_adr = a; int_dbo = d;
        t = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (int_ready) begin t = cyc; break; end
        end
        n_checks++;
        if (t < 0) begin
            n_fail++; $display("FAIL int_issue_timeout: int_ready never seen for adr %0d", a);
        end else if ({vdp_req, vdp_wrt, vdp_adr} !== {1'b1, w, a} || (w && vdp_dbo !== d)) begin
            n_fail++;
            $display("FAIL int_issue_beat: got req=%b wrt=%b adr=%0d dbo=%h, expected req=1 wrt=%b adr=%0d dbo=%h",
                     vdp_req, vdp_wrt, vdp_adr, vdp_dbo, w, a, d);
        end
        tick();
        int_valid = 1'b0;
    endtask

    task automatic cpu_pulse(input logic [1:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_wrt = 1'b1; cpu_adr = a; cpu_dbo = d;
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_req = 0; cpu_wrt = 0; cpu_adr = 0; cpu_dbo = 0;
        int_valid = 0; int_wrt = 0; int_adr = 0; int_dbo = 0; vdp_dbi = 0;
        repeat (2) tick();
        n_checks++;
        if ({vdp_req, vdp_wrt, vdp_adr, vdp_dbo, int_ready, int_rvalid, int_rdata, lock_tmo, cpu_ovf} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got req=%b dbo=%h rdy=%b rv=%b ovf=%b tmo=%b, expected all 0",
                               vdp_req, vdp_dbo, int_ready, int_rvalid, cpu_ovf, lock_tmo);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (vdp_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle: vdp_req=%b expected 0", vdp_req); end
    endtask

    task automatic test_int_write();
        int s, t;
        repeat (3) tick();
        s = cyc;
        int_issue(1'b1, 2'd0, 8'h55, t);
        n_checks++;
        if (t !== s + 1) begin n_fail++; $display("FAIL int_write_latency: issue cycle %0d expected %0d", t, s + 1); end
        n_checks++;
        if (vdp_req !== 1'b0) begin n_fail++; $display("FAIL int_write_single: vdp_req=%b after issue, expected 0", vdp_req); end
    endtask

    task automatic test_pair_lock();
        int t0, t1, t2;
        repeat (3) tick();
        int_issue(1'b1, 2'd1, 8'h00, t0);
        cpu_pulse(2'd0, 8'hAA);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (vdp_req !== 1'b0) begin n_fail++; $display("FAIL pair_lock_hold: vdp_req=%b dbo=%h during int lock, expected 0", vdp_req, vdp_dbo); end
            tick();
        end
        int_issue(1'b1, 2'd1, 8'h87, t1);
        t2 = -1;
        for (int i = 0; i < 10; i++) begin
            if (vdp_req) begin t2 = cyc; break; end
            tick();
        end
        n_checks++;
        if (t2 < 0 || vdp_dbo !== 8'hAA || vdp_adr !== 2'd0 || vdp_wrt !== 1'b1) begin
            n_fail++; $display("FAIL pair_lock_release: got cycle %0d dbo=%h adr=%0d, expected queued AA on port 0", t2, vdp_dbo, vdp_adr);
        end
        n_checks++;
        if (t2 - t1 < 2) begin n_fail++; $display("FAIL pair_lock_gap: req spacing %0d expected >= 2", t2 - t1); end
    endtask

    task automatic test_lock_timeout();
        int t0, tt, early;
        repeat (3) tick();
        int_issue(1'b1, 2'd1, 8'h12, t0);
        cpu_pulse(2'd3, 8'h3C);
        tt = -1; early = 0;
        for (int i = 0; i < 100; i++) begin
            if (lock_tmo) begin tt = cyc; break; end
            if (vdp_req) early++;
            tick();
        end
        n_checks++;
        if (tt !== t0 + 64) begin n_fail++; $display("FAIL lock_tmo_cycle: pulse at %0d expected %0d", tt, t0 + 64); end
        n_checks++;
        if (early !== 0) begin n_fail++; $display("FAIL lock_tmo_hold: %0d issues before timeout, expected 0", early); end
        tick();
        n_checks++;
        if ({vdp_req, vdp_adr, vdp_dbo} !== {1'b1, 2'd3, 8'h3C}) begin
            n_fail++; $display("FAIL lock_tmo_next: got req=%b adr=%0d dbo=%h expected req=1 adr=3 dbo=3c", vdp_req, vdp_adr, vdp_dbo);
        end
        n_checks++;
        if (lock_tmo !== 1'b0) begin n_fail++; $display("FAIL lock_tmo_pulse: lock_tmo=%b one cycle later, expected 0", lock_tmo); end
    endtask

    task automatic test_fifo_overflow();
        int t0, t1, got;
        logic [7:0] seen [8];
        repeat (3) tick();
        n_checks++;
        if (cpu_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_initial: cpu_ovf=%b expected 0", cpu_ovf); end
        int_issue(1'b1, 2'd2, 8'h20, t0);
        for (int k = 1; k <= 4; k++) cpu_pulse(2'd0, 8'(k));
        n_checks++;
        if (cpu_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: cpu_ovf=%b after 4 pushes, expected 0", cpu_ovf); end
        cpu_pulse(2'd0, 8'h05);
        n_checks++;
        if (cpu_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: cpu_ovf=%b after 5th push, expected 1", cpu_ovf); end
        int_issue(1'b1, 2'd2, 8'h21, t1);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (vdp_req) begin
                if (got < 8) seen[got] = vdp_dbo;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 4) begin n_fail++; $display("FAIL ovf_issue_count: %0d bridge issues, expected 4", got); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (seen[k] !== 8'(k + 1)) begin n_fail++; $display("FAIL ovf_order: issue %0d dbo=%h expected %h", k, seen[k], 8'(k + 1)); end
        end
        n_checks++;
        if (cpu_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: cpu_ovf=%b expected 1", cpu_ovf); end
    endtask

    task automatic test_int_read();
        int t0;
        repeat (3) tick();
        int_issue(1'b0, 2'd1, 8'h00, t0);
        vdp_dbi = 8'h11;
        #1;
        n_checks++;
        if (int_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_early: int_rvalid=%b at req+1, expected 0", int_rvalid); end
        tick();
        vdp_dbi = 8'h9F;
        #1;
        n_checks++;
        if (int_rvalid !== 1'b1 || int_rdata !== 8'h9F) begin
            n_fail++; $display("FAIL rd_capture: rvalid=%b rdata=%h at req+2, expected 1 / 9f", int_rvalid, int_rdata);
        end
        tick();
        vdp_dbi = 8'h00;
        #1;
        n_checks++;
        if (int_rvalid !== 1'b0 || int_rdata !== 8'h9F) begin
            n_fail++; $display("FAIL rd_hold: rvalid=%b rdata=%h at req+3, expected 0 / 9f", int_rvalid, int_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        repeat (3) tick();
        cpu_req = 1'b1; cpu_wrt = 1'b1; cpu_adr = 2'd1; cpu_dbo = 8'h00;
        int_valid = 1'b1; int_wrt = 1'b1; int_adr = 2'd0; int_dbo = 8'h77;
        tick();
        n_checks++;
        if ({vdp_req, vdp_adr, vdp_dbo, int_ready} !== {1'b1, 2'd1, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL tie_bridge_wins: got req=%b adr=%0d dbo=%h rdy=%b expected req=1 adr=1 dbo=00 rdy=0",
                               vdp_req, vdp_adr, vdp_dbo, int_ready);
        end
        cpu_adr = 2'd0; cpu_dbo = 8'hB1;
        tick();
        cpu_dbo = 8'hB2;
        tick();
        cpu_req = 1'b0;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({vdp_req, vdp_wrt, vdp_adr, vdp_dbo, int_ready, int_rvalid, int_rdata, lock_tmo, cpu_ovf} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got req=%b rdy=%b rv=%b ovf=%b tmo=%b, expected all 0",
                               vdp_req, int_ready, int_rvalid, cpu_ovf, lock_tmo);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({vdp_req, int_ready, vdp_adr, vdp_dbo} !== {1'b1, 1'b1, 2'd0, 8'h77}) begin
            n_fail++; $display("FAIL reset_mid_int_next: got req=%b rdy=%b adr=%0d dbo=%h expected int write 77 on port 0",
                               vdp_req, int_ready, vdp_adr, vdp_dbo);
        end
        tick();
        int_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (vdp_req) extra++;
            tick();
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL reset_mid_fifo: %0d issues after reset, expected 0 (queue flushed)", extra); end
    endtask

    initial begin
        test_reset();
        test_int_write();
        test_pair_lock();
        test_lock_timeout();
        test_fifo_overflow();
        test_int_read();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
